// File: rtl/noise_shaping_quantizer.sv
// Error-feedback noise-shaping quantizer (orders 0..2) with a one-deep output register.
// Define QUANT_DITHER_EN to add LFSR triangular-free uniform dither ahead of the rounding step.
module noise_shaping_quantizer #(
    parameter int IN_W      = 16,
    parameter int OUT_W     = 4,
    parameter int MAX_LEVEL = (1 << OUT_W) - 1,
    parameter int ORDER     = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clear_i,
    input  logic signed [IN_W-1:0] x_in_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    output logic [OUT_W-1:0]       quantized_out_o,
    output logic signed [IN_W-1:0] quant_error_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic                   sat_o,
    output logic [15:0]            sat_count_o
);
    localparam int SH   = IN_W - OUT_W;
    localparam int VW   = IN_W + 3;
    localparam int STEP = 1 << SH;
    localparam int MID  = 1 << (OUT_W - 1);

    localparam logic signed [VW-1:0] HALF_V = VW'(STEP / 2);
    localparam logic signed [VW-1:0] MID_V  = VW'(MID);
    localparam logic signed [VW-1:0] MAXL_V = VW'(MAX_LEVEL);
    localparam logic signed [VW-1:0] ZERO_V = '0;
    localparam logic signed [VW-1:0] ERR_HI = VW'(STEP - 1);
    localparam logic signed [VW-1:0] ERR_LO = VW'(-STEP);

    logic [OUT_W-1:0]       level_q, level_d;
    logic signed [IN_W-1:0] err_q, err_d;
    logic signed [IN_W-1:0] e1_q, e1_d, e2_q, e2_d;
    logic                   valid_q, valid_d;
    logic                   sat_q, sat_d;
    logic [15:0]            cnt_q, cnt_d;

    logic                   accept;
    logic signed [VW-1:0]   x_ext, e1x, e2x, fb, dith, v, vr, q, level, level_c, rec, diff;
    logic                   sat_now;
    logic signed [IN_W-1:0] err_w;

    assign ready_o = !valid_q || ready_i;
    assign accept  = valid_i && ready_o;

`ifdef QUANT_DITHER_EN
    localparam logic signed [VW-1:0] DITH_OFF = VW'(STEP / 8);
    logic [15:0] lfsr_q, lfsr_d;
    logic        lfsr_fb;

    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign lfsr_d  = accept ? {lfsr_q[14:0], lfsr_fb} : lfsr_q;
    assign dith    = $signed({{(VW - SH + 2){1'b0}}, lfsr_q[SH-3:0]}) - DITH_OFF;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign dith = '0;
`endif

    always_comb begin
        x_ext = {{3{x_in_i[IN_W-1]}}, x_in_i};
        // A clear in the accept cycle means this sample sees no feedback at all.
        e1x   = clear_i ? ZERO_V : {{3{e1_q[IN_W-1]}}, e1_q};
        e2x   = clear_i ? ZERO_V : {{3{e2_q[IN_W-1]}}, e2_q};
        case (ORDER)
            0:       fb = ZERO_V;
            1:       fb = e1x;
            default: fb = (e1x <<< 1) - e2x;
        endcase
        v     = x_ext + fb + dith;
        vr    = v + HALF_V;
        q     = vr >>> SH;
        level = q + MID_V;

        sat_now = 1'b0;
        level_c = level;
        if (level < ZERO_V) begin
            level_c = ZERO_V;
            sat_now = 1'b1;
        end else if (level > MAXL_V) begin
            level_c = MAXL_V;
            sat_now = 1'b1;
        end

        rec  = (level_c - MID_V) <<< SH;
        diff = v - rec;
        if (diff > ERR_HI) begin
            err_w = ERR_HI[IN_W-1:0];
        end else if (diff < ERR_LO) begin
            err_w = ERR_LO[IN_W-1:0];
        end else begin
            err_w = diff[IN_W-1:0];
        end
    end

    always_comb begin
        level_d = level_q;
        err_d   = err_q;
        sat_d   = sat_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        e1_d    = e1_q;
        e2_d    = e2_q;
        if (accept) begin
            level_d = level_c[OUT_W-1:0];
            err_d   = err_w;
            sat_d   = sat_now;
            valid_d = 1'b1;
            e1_d    = err_w;
            e2_d    = clear_i ? '0 : e1_q;
            if (sat_now && cnt_q != 16'hFFFF) begin
                cnt_d = cnt_q + 16'd1;
            end
        end else begin
            if (ready_i) begin
                valid_d = 1'b0;
            end
            if (clear_i) begin
                e1_d = '0;
                e2_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            level_q <= '0;
            err_q   <= '0;
            sat_q   <= 1'b0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            e1_q    <= '0;
            e2_q    <= '0;
        end else begin
            level_q <= level_d;
            err_q   <= err_d;
            sat_q   <= sat_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            e1_q    <= e1_d;
            e2_q    <= e2_d;
        end
    end

    assign quantized_out_o = level_q;
    assign quant_error_o   = err_q;
    assign valid_o         = valid_q;
    assign sat_o           = sat_q;
    assign sat_count_o     = cnt_q;
endmodule

// File: doc/noise_shaping_quantizer.md
NOISE_SHAPING_QUANTIZER -- requirements
Module: noise_shaping_quantizer

Interface
REQ-001 SHALL have parameter IN_W, default 16: signed input, error and feedback width.
REQ-002 SHALL have parameter OUT_W, default 4: output level width; STEP = 2^(IN_W-OUT_W), MID = 2^(OUT_W-1).
REQ-003 SHALL have parameter MAX_LEVEL, default 2^OUT_W-1: upper output clamp.
REQ-004 SHALL have parameter ORDER, default 1: error feedback order; legal values 0, 1, 2.
REQ-005 SHALL have port clk_i  input  1  single clock, all logic on its rising edge.
REQ-006 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port clear_i  input  1  synchronous clear of the error-feedback state.
REQ-008 SHALL have port x_in_i  input  IN_W  signed two's-complement sample.
REQ-009 SHALL have port valid_i  input  1  x_in_i valid.
REQ-010 SHALL have port ready_o  output  1  block accepts a sample this cycle.
REQ-011 SHALL have port quantized_out_o  output  OUT_W  unsigned level 0..MAX_LEVEL.
REQ-012 SHALL have port quant_error_o  output  IN_W  signed quantization error of the same sample.
REQ-013 SHALL have port valid_o  output  1  output valid.
REQ-014 SHALL have port ready_i  input  1  downstream accepts the output.
REQ-015 SHALL have port sat_o  output  1  output sample was clamped.
REQ-016 SHALL have port sat_count_o  output  16  clamped-sample counter, saturating at 0xFFFF.

Function
REQ-017 SHALL accept a sample when valid_i && ready_o; ready_o = !valid_o || ready_i.
REQ-018 SHALL present an accepted sample's result one cycle later; valid_o SHALL clear on a cycle with ready_i=1 and no accept.
REQ-019 SHALL hold all outputs and freeze error state, LFSR and counter while valid_o=1 and ready_i=0.
REQ-020 SHALL form v = x (ORDER 0), x + e1 (ORDER 1) or x + 2*e1 - e2 (ORDER 2), computed at IN_W+3 bits without overflow.
REQ-021 SHALL compute q = floor((v + STEP/2) / STEP) with arithmetic shift, so ties round toward +inf; level = q + MID.
REQ-022 SHALL clamp level to [0, MAX_LEVEL], setting sat_o=1 when clamped and 0 otherwise.
REQ-023 SHALL compute err = v - (clamped level - MID)*STEP, saturated to [-STEP, STEP-1]; this value drives quant_error_o.
REQ-024 SHALL on every accept shift the error state: e2 <= e1, e1 <= err; the state is not updated without an accept.
REQ-025 SHALL on clear_i=1 zero e1 and e2 before forming v; a sample accepted in the same cycle uses zero feedback, and its own err is still stored.
REQ-026 SHALL increment sat_count_o on each accepted sample that is clamped.

Reset
REQ-027 SHALL, on rst_i high (asynchronous, at any time including mid-transfer), force quantized_out_o=0, quant_error_o=0, valid_o=0, sat_o=0, sat_count_o=0, e1=e2=0, and set the LFSR to its seed; ready_o SHALL read 1.

Configuration
REQ-028 SHALL, with macro QUANT_DITHER_EN defined, add dither d to v: a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, seed 0xACE1) advances once per accept, and d = lfsr[IN_W-OUT_W-3:0] - STEP/8, giving range [-STEP/8, STEP/8). This mode requires IN_W-OUT_W >= 3.
REQ-029 SHALL, without QUANT_DITHER_EN, contain no LFSR and use d = 0.

Verification (IN_W=16, OUT_W=4, STEP=4096, MID=8, dither off)
REQ-030 SHALL check reset: assert rst_i mid-stream -> all outputs 0 and ready_o=1 in the same cycle; the first post-reset sample uses zero feedback.
REQ-031 SHALL check ORDER=0 rounding:
- x=0 -> level 8, err 0.
- x=12288 -> level 11, err 0.
- x=2048 -> level 9, err -2048.
- x=-2049 -> level 7, err 2047.
REQ-032 SHALL check saturation with ORDER=0:
- x=32767 -> level 15, err 4095, sat_o=1, sat_count_o=1.
- x=-32768 -> level 0, err 0, sat_o=0.
REQ-033 SHALL check ORDER=1 with constant x=1024 -> levels 8,9,8,8 repeating and errors 1024,-2048,-1024,0 repeating.
REQ-034 SHALL check backpressure: hold ready_i=0 for 5 cycles with valid_i=1 -> outputs stable, ready_o=0, no state advance; on release the next sample continues the sequence exactly.
REQ-035 SHALL check clear_i coincident with an accept in ORDER=2 after a nonzero history -> v = x for that sample, and the following sample uses e1 = that sample's err and e2 = 0.
